// File: rtl/if_seq_pkg.sv
// Shared constants for the instruction-fetch sequencer: opcodes, next-PC selects, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a. The IF_SEQ_BZ_EN macro enables the OP_BZ conditional branch.
package if_seq_pkg;

  // Opcode field values, instr[15:12]
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_RET  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;
  localparam logic [3:0] OP_BZ   = 4'hB;

  // Next-PC mux selects driven on mux1CR
  localparam logic [1:0] SEL_LR   = 2'b00;  // return address from LR
  localparam logic [1:0] SEL_INC  = 2'b01;  // sequential PC+1
  localparam logic [1:0] SEL_TGT  = 2'b10;  // absolute target instr[7:0]
  localparam logic [1:0] SEL_ZERO = 2'b11;  // reset vector 8'h00

  // Sequencer FSM encoding
  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  // Instruction classes produced by the opcode decoder
  typedef enum logic [2:0] {
    CLS_DP   = 3'd0,
    CLS_JMP  = 3'd1,
    CLS_CALL = 3'd2,
    CLS_RET  = 3'd3,
    CLS_HLT  = 3'd4,
    CLS_BZ   = 3'd5
  } iclass_t;

endpackage

// File: rtl/if_seq_decode.sv
// Opcode classifier: maps instr[15:12] to the instruction class used by the sequencer.
// Latency: purely combinational, zero cycles.
// Backpressure: none; stall handling lives in the sequencer. OP_BZ decodes only with IF_SEQ_BZ_EN.
module if_seq_decode
  import if_seq_pkg::*;
(
  input  logic [3:0] opcode,
  output iclass_t    iclass
);

  // Anything that is not a fetch-resolved control opcode goes to the datapath
  always_comb begin
    iclass = CLS_DP;
    case (opcode)
      OP_JMP:  iclass = CLS_JMP;
      OP_CALL: iclass = CLS_CALL;
      OP_RET:  iclass = CLS_RET;
      OP_HLT:  iclass = CLS_HLT;
`ifdef IF_SEQ_BZ_EN
      OP_BZ:   iclass = CLS_BZ;
`endif
      default: iclass = CLS_DP;
    endcase
  end

endmodule

// File: rtl/if_sequencer.sv
// Fetch-stage control sequencer: next-PC select, PC/LR load enables, decode valid, retired count.
// Latency: controls are combinational from instr and state; PC/LR update on the next edge (zero-bubble redirects).
// Backpressure: stall freezes PC/LR and the counter; valid keeps its decoded value. IF_SEQ_BZ_EN adds the BZ branch.
module if_sequencer
  import if_seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      instr,
  input  logic             stall,
  input  logic             zero,
  input  logic             resume,
  output logic [1:0]       mux1CR,
  output logic             PCCR,
  output logic             LRCR,
  output logic             valid,
  output logic             halted,
  output logic [CNT_W-1:0] icount
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0] state;
  logic [1:0] state_nxt;
  iclass_t    iclass;

  // Target and operand bits belong to the datapath; zero is only consumed by the BZ build
  logic       unused_inputs;
  assign unused_inputs = ^{instr[11:0], zero};

  if_seq_decode u_decode (
    .opcode (instr[15:12]),
    .iclass (iclass)
  );

  // Next-state and control decode; outputs are held at their idle values while rst is high
  always_comb begin
    mux1CR    = SEL_INC;
    PCCR      = 1'b0;
    LRCR      = 1'b0;
    valid     = 1'b0;
    halted    = 1'b0;
    state_nxt = state;
    if (!rst) begin
      case (state)
        BOOT: begin
          // Force PC to the reset vector before the first real fetch
          mux1CR    = SEL_ZERO;
          PCCR      = 1'b1;
          state_nxt = RUN;
        end
        RUN: begin
          // Valid reflects the decode even under stall so decode sees a steady offer
          valid = (iclass == CLS_DP);
          if (!stall) begin
            case (iclass)
              CLS_DP: begin
                mux1CR = SEL_INC;
                PCCR   = 1'b1;
              end
              CLS_JMP: begin
                mux1CR = SEL_TGT;
                PCCR   = 1'b1;
              end
              CLS_CALL: begin
                // LR captures PC+1 on the same edge PC takes the target
                mux1CR = SEL_TGT;
                PCCR   = 1'b1;
                LRCR   = 1'b1;
              end
              CLS_RET: begin
                mux1CR = SEL_LR;
                PCCR   = 1'b1;
              end
              CLS_HLT: begin
                // PC stays on the HLT so resume can step past it
                state_nxt = HALT;
              end
`ifdef IF_SEQ_BZ_EN
              CLS_BZ: begin
                mux1CR = zero ? SEL_TGT : SEL_INC;
                PCCR   = 1'b1;
              end
`endif
              default: begin
                mux1CR = SEL_INC;
                PCCR   = 1'b0;
              end
            endcase
          end
        end
        HALT: begin
          halted = 1'b1;
          if (resume) begin
            mux1CR    = SEL_INC;
            PCCR      = 1'b1;
            state_nxt = RUN;
          end
        end
        default: state_nxt = BOOT;
      endcase
    end
  end

  // State register; reset lands in BOOT so the PC gets cleared on the first cycle out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Retired-instruction counter: counts accepted datapath offers, saturates at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icount <= '0;
    end else if (valid && !stall && (icount != CNT_MAX)) begin
      icount <= icount + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_if_sequencer.sv
// Self-checking bench for if_sequencer: scoreboard of per-cycle expected control outputs.
// Latency: one expectation per fetch cycle, sampled on the falling edge.
// Backpressure: stall cycles are modelled by freezing the expected retired count.
module tb_if_sequencer;
  import if_seq_pkg::*;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [15:0]      instr = 16'h0000;
  logic             stall = 1'b0;
  logic             zero = 1'b0;
  logic             resume = 1'b0;
  logic [1:0]       mux1CR;
  logic             PCCR;
  logic             LRCR;
  logic             valid;
  logic             halted;
  logic [CNT_W-1:0] icount;

  typedef struct packed {
    logic [1:0]  mux;
    logic        pc;
    logic        lr;
    logic        vld;
    logic        hlt;
    logic [15:0] cnt;
  } obs_t;

  obs_t        sb[$];
  obs_t        got;
  obs_t        e;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [15:0] exp_cnt = 16'h0000;

  assign got = {mux1CR, PCCR, LRCR, valid, halted, icount};

  if_sequencer #(.CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .instr  (instr),
    .stall  (stall),
    .zero   (zero),
    .resume (resume),
    .mux1CR (mux1CR),
    .PCCR   (PCCR),
    .LRCR   (LRCR),
    .valid  (valid),
    .halted (halted),
    .icount (icount)
  );

  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

  // Queue the expected outputs for the next cycle and advance the reference retired count
  task automatic push(input logic [1:0] m, input logic p, input logic l,
                      input logic v, input logic h, input logic s);
    sb.push_back({m, p, l, v, h, exp_cnt});
    if (v && !s && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'h0001;
  endtask

  // Drive one fetch cycle: inputs change just after the rising edge, outputs sampled at the falling edge
  task automatic apply(input logic [15:0] i, input logic s, input logic r, input logic z);
    @(posedge clk);
    #1;
    instr = i; stall = s; resume = r; zero = z;
    @(negedge clk);
  endtask

  task automatic test_reset;
    instr = 16'h1234;
    #12;
    n_chk++;
    if (got !== {SEL_INC, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000})
      $display("FAIL reset_hold: got %h required %h", got, {SEL_INC, 4'b0000, 16'h0000});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++;
    if (got !== {SEL_ZERO, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000})
      $display("FAIL boot: got %h required %h", got, {SEL_ZERO, 4'b1000, 16'h0000});
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      push(SEL_INC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      apply(16'h1234, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front(); n_chk++;
      if (got !== e) $display("FAIL datapath_%0d: got %h required %h", k, got, e);
      else n_pass++;
    end
  endtask

  task automatic test_call_ret;
    push(SEL_TGT, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(16'hD042, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL call: got %h required %h", got, e);
    else n_pass++;
    push(SEL_LR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(16'hE000, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL ret: got %h required %h", got, e);
    else n_pass++;
    // Call to its own address is a legal loop, not a halt
    push(SEL_TGT, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(16'hD000, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL call_self: got %h required %h", got, e);
    else n_pass++;
  endtask

  task automatic test_stall;
    for (int k = 0; k < 4; k++) begin
      push(SEL_INC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      apply(16'h1111, 1'b1, 1'b0, 1'b0);
      e = sb.pop_front(); n_chk++;
      if (got !== e) $display("FAIL stall_dp_%0d: got %h required %h", k, got, e);
      else n_pass++;
    end
    for (int k = 0; k < 4; k++) begin
      push(SEL_INC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      apply(16'hC010, 1'b1, 1'b0, 1'b0);
      e = sb.pop_front(); n_chk++;
      if (got !== e) $display("FAIL stall_jmp_%0d: got %h required %h", k, got, e);
      else n_pass++;
    end
    push(SEL_TGT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(16'hC010, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL jmp_release: got %h required %h", got, e);
    else n_pass++;
    push(SEL_INC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    apply(16'h1111, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL dp_release: got %h required %h", got, e);
    else n_pass++;
  endtask

  task automatic test_halt;
    push(SEL_INC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(16'hF000, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL hlt_fetch: got %h required %h", got, e);
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      push(SEL_INC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      apply(16'hF000, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front(); n_chk++;
      if (got !== e) $display("FAIL halted_%0d: got %h required %h", k, got, e);
      else n_pass++;
    end
    push(SEL_INC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(16'hF000, 1'b0, 1'b1, 1'b0);
    e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL resume: got %h required %h", got, e);
    else n_pass++;
    push(SEL_INC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    apply(16'h2345, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL after_resume: got %h required %h", got, e);
    else n_pass++;
  endtask

  task automatic test_resume_ignored;
    push(SEL_INC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    apply(16'h3456, 1'b0, 1'b1, 1'b0);
    e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL resume_in_run: got %h required %h", got, e);
    else n_pass++;
    push(SEL_TGT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(16'hC020, 1'b0, 1'b1, 1'b0);
    e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL resume_jmp: got %h required %h", got, e);
    else n_pass++;
  endtask

  task automatic test_bz;
`ifdef IF_SEQ_BZ_EN
    push(SEL_TGT, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(16'hB020, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL bz_taken: got %h required %h", got, e);
    else n_pass++;
    push(SEL_INC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(16'hB020, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL bz_not_taken: got %h required %h", got, e);
    else n_pass++;
`else
    push(SEL_INC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    apply(16'hB020, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL bz_as_dp_z1: got %h required %h", got, e);
    else n_pass++;
    push(SEL_INC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    apply(16'hB020, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL bz_as_dp_z0: got %h required %h", got, e);
    else n_pass++;
`endif
    // Control opcode with zero toggled must be unaffected by it
    push(SEL_LR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(16'hE000, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL ret_zero: got %h required %h", got, e);
    else n_pass++;
  endtask

  task automatic test_saturate_and_reset;
    int runs;
    runs = 0;
    while (exp_cnt != 16'hFFFF && runs < 70000) begin
      push(SEL_INC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      apply(16'h4321, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front(); n_chk++;
      if (got !== e) $display("FAIL long_run_%0d: got %h required %h", runs, got, e);
      else n_pass++;
      runs++;
    end
    for (int k = 0; k < 3; k++) begin
      push(SEL_INC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      apply(16'h4321, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front(); n_chk++;
      if (got !== e) $display("FAIL saturate_%0d: got %h required %h", k, got, e);
      else n_pass++;
    end
    push(SEL_INC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(16'hF000, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL sat_hlt: got %h required %h", got, e);
    else n_pass++;
    push(SEL_INC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(16'hF000, 1'b0, 1'b0, 1'b0);
    e = sb.pop_front(); n_chk++;
    if (got !== e) $display("FAIL sat_halted: got %h required %h", got, e);
    else n_pass++;
    // Assert reset between edges; state and count must clear without a clock
    #2;
    rst = 1'b1;
    #1;
    exp_cnt = 16'h0000;
    n_chk++;
    if (got !== {SEL_INC, 1'b0, 1'b0, 1'b0, 1'b0, exp_cnt})
      $display("FAIL async_reset: got %h required %h", got, {SEL_INC, 4'b0000, exp_cnt});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++;
    if (got !== {SEL_ZERO, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000})
      $display("FAIL reboot: got %h required %h", got, {SEL_ZERO, 4'b1000, 16'h0000});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_call_ret();
    test_stall();
    test_halt();
    test_resume_ignored();
    test_bz();
    test_saturate_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
